gof_generation_engine: RTL and testbench

- Downstream consumer of the 300-cell Game-of-Life RAM (15 rows x 20 columns; address = column*15 + row).
- On each step request it sweeps all cells, reading the current cell and its 8-bit neighbour vector, and applies the Life rules.
- Next states are held in an internal 300-bit buffer, then written back in a separate commit pass so that reads never see partially updated data.
- When idle, the external (editor/display) address, data and write-enable pass straight through to the RAM.

---
 rtl/gof_generation_engine.sv | 169 ++++++++++++++++
 tb/tb_gof_generation_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gof_generation_engine.sv
// rtl/gof_generation_engine.sv - Game-of-Life generation engine: scan pass into a next-state buffer, then commit pass.
// Optional macro GOF_FREEZE_DETECT_EN: skip the commit pass when a generation changes no cell.
module gof_generation_engine #(
  parameter int CELLS  = 300,
  parameter int ADDR_W = 9,
  parameter int GEN_W  = 16
) (
  input  logic              clk_50MHz_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic              ext_data_i,
  input  logic              ext_we_i,
  input  logic              Data_i,
  input  logic [7:0]        Neigh_i,
  output logic [ADDR_W-1:0] Address_o,
  output logic              Data_o,
  output logic              w_e_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [GEN_W-1:0]  gen_count_o,
  output logic [8:0]        alive_count_o,
  output logic              stable_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [CELLS-1:0]  r_next_buf;
  logic [8:0]        r_acc;
  logic [8:0]        r_alive;
  logic [GEN_W-1:0]  r_gen;
  logic [3:0]        w_n;
  logic              w_next;
  logic              w_last;

`ifdef GOF_FREEZE_DETECT_EN
  logic r_changed;
  logic r_stable;
  logic w_changed_any;

  // Includes the cell under scan so the decision at the last cell is complete.
  assign w_changed_any = r_changed | (w_next != Data_i);
  assign stable_o      = r_stable;
`else
  assign stable_o = 1'b0;
`endif

  always_comb begin
    w_n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_n = w_n + 4'(Neigh_i[i]);
    end
  end

  assign w_next = (w_n == 4'd3) | (Data_i & (w_n == 4'd2));
  assign w_last = (r_idx == ADDR_W'(CELLS - 1));

  always_ff @(posedge clk_50MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_next_buf <= '0;
      r_acc      <= '0;
      r_alive    <= '0;
      r_gen      <= '0;
`ifdef GOF_FREEZE_DETECT_EN
      r_changed  <= 1'b0;
      r_stable   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_acc     <= '0;
`ifdef GOF_FREEZE_DETECT_EN
            r_changed <= 1'b0;
`endif
          end
        end
        S_SCAN: begin
          r_next_buf[r_idx] <= w_next;
          r_acc             <= r_acc + 9'(w_next);
`ifdef GOF_FREEZE_DETECT_EN
          r_changed         <= w_changed_any;
`endif
        end
        S_DONE: begin
          r_gen    <= r_gen + GEN_W'(1);
          r_alive  <= r_acc;
`ifdef GOF_FREEZE_DETECT_EN
          r_stable <= ~r_changed;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    Address_o   = ext_addr_i;
    Data_o      = ext_data_i;
    w_e_o       = ext_we_i;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        Address_o = r_idx;
        Data_o    = 1'b0;
        w_e_o     = 1'b0;
        if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_COMMIT;
`ifdef GOF_FREEZE_DETECT_EN
          if (!w_changed_any) begin
            w_state_nxt = S_DONE;
          end
`endif
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      S_COMMIT: begin
        Address_o = r_idx;
        Data_o    = r_next_buf[r_idx];
        w_e_o     = 1'b1;
        if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      S_DONE: begin
        Address_o   = r_idx;
        Data_o      = 1'b0;
        w_e_o       = 1'b0;
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign gen_count_o   = r_gen;
  assign alive_count_o = r_alive;

endmodule

// File: tb/tb_gof_generation_engine.sv
// tb/tb_gof_generation_engine.sv - self-checking bench: behavioural 15x20 RAM/grid model, per-cycle compare, directed cases.
module tb_gof_generation_engine;

`ifdef GOF_FREEZE_DETECT_EN
  localparam bit FRZ = 1'b1;
`else
  localparam bit FRZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  ext_addr = 9'd37;
  logic        ext_data = 1'b0;
  logic        ext_we = 1'b0;
  logic        data_in;
  logic [7:0]  neigh_in;
  logic [8:0]  Address_o;
  logic        Data_o;
  logic        w_e_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] gen_count_o;
  logic [8:0]  alive_count_o;
  logic        stable_o;

  int n_vec = 0;
  int n_err = 0;

  logic [299:0] grid = '0;

  gof_generation_engine dut (
    .clk_50MHz_i  (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .ext_addr_i   (ext_addr),
    .ext_data_i   (ext_data),
    .ext_we_i     (ext_we),
    .Data_i       (data_in),
    .Neigh_i      (neigh_in),
    .Address_o    (Address_o),
    .Data_o       (Data_o),
    .w_e_o        (w_e_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .gen_count_o  (gen_count_o),
    .alive_count_o(alive_count_o),
    .stable_o     (stable_o)
  );

  always #10 clk = ~clk;

  // Neighbours of a cell; cells outside the 15x20 field count as dead.
  function automatic logic [7:0] nvec(input logic [299:0] g, input int a);
    logic [7:0] v;
    int r, c, k, rr, cc;
    v = '0;
    k = 0;
    if (a < 0 || a >= 300) return 8'h00;
    r = a % 15;
    c = a / 15;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          rr = r + dr;
          cc = c + dc;
          if (rr >= 0 && rr < 15 && cc >= 0 && cc < 20) v[k] = g[cc*15 + rr];
          k++;
        end
      end
    end
    return v;
  endfunction

  function automatic logic [299:0] life(input logic [299:0] g);
    logic [299:0] r;
    int n;
    for (int a = 0; a < 300; a++) begin
      n = $countones(nvec(g, a));
      r[a] = (n == 3) || (g[a] && n == 2);
    end
    return r;
  endfunction

  assign neigh_in = nvec(grid, int'(Address_o));
  assign data_in  = (Address_o < 9'd300) ? grid[Address_o] : 1'b0;

  always @(posedge clk) begin
    if (w_e_o && Address_o < 9'd300) grid[Address_o] <= Data_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_k counts busy cycles 1..m_len after an accepted start, 0 when idle.
  int           m_k = 0;
  int           m_len = 601;
  logic [299:0] m_next = '0;
  logic         m_stab_pend = 1'b0;
  logic [15:0]  m_gen = '0;
  logic [8:0]   m_alive = '0;
  logic         m_stable = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k      <= 0;
      m_gen    <= '0;
      m_alive  <= '0;
      m_stable <= 1'b0;
    end else if (m_k == 0) begin
      if (start) begin
        m_k         <= 1;
        m_next      <= life(grid);
        m_stab_pend <= FRZ && (life(grid) == grid);
        m_len       <= (FRZ && (life(grid) == grid)) ? 301 : 601;
      end
    end else if (m_k == m_len) begin
      m_k      <= 0;
      m_gen    <= m_gen + 16'd1;
      m_alive  <= 9'($countones(m_next));
      m_stable <= m_stab_pend;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (m_k == 0) begin
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_addr", Address_o, ext_addr);
      chk("idle_data", Data_o, ext_data);
      chk("idle_we", w_e_o, ext_we);
    end else begin
      chk("run_busy", busy_o, 1);
      chk("run_done", done_o, (m_k == m_len));
      chk("run_addr_range", Address_o < 9'd300, 1);
      if (m_k <= 300) begin
        chk("scan_addr", Address_o, m_k - 1);
        chk("scan_we", w_e_o, 0);
      end else if (m_k <= 600 && m_len == 601) begin
        chk("commit_addr", Address_o, m_k - 301);
        chk("commit_we", w_e_o, 1);
        chk("commit_data", Data_o, m_next[m_k-301]);
      end else begin
        chk("done_we", w_e_o, 0);
      end
    end
    chk("gen_count", gen_count_o, m_gen);
    chk("alive_count", alive_count_o, m_alive);
    chk("stable", stable_o, m_stable);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [299:0] pat);
    int bad;
    for (int a = 0; a < 300; a++) begin
      ext_addr = 9'(a);
      ext_data = pat[a];
      ext_we   = 1'b1;
      tick();
    end
    ext_we   = 1'b0;
    ext_data = 1'b0;
    ext_addr = 9'd37;
    bad = 0;
    for (int a = 0; a < 300; a++) if (grid[a] !== pat[a]) bad++;
    chk("load_grid", bad, 0);
  endtask

  task automatic step(output int blen, output int wcnt, output int dcnt, output int dlast);
    int guard;
    blen = 0; wcnt = 0; dcnt = 0; dlast = 0; guard = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    while (busy_o && guard < 2000) begin
      blen++;
      if (w_e_o) wcnt++;
      if (done_o) begin
        dcnt++;
        dlast = blen;
      end
      guard++;
      @(negedge clk);
    end
    chk("step_timeout", guard >= 2000, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [299:0] pat;
    int blen, wcnt, dcnt, dlast, n, g;

    #5 rst_n = 1'b0;
    #3;
    chk("rst_addr_follows_ext", Address_o, 37);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_gen", gen_count_o, 0);
    chk("rst_alive", alive_count_o, 0);
    chk("rst_stable", stable_o, 0);
    chk("rst_we", w_e_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Vertical blinker -> horizontal -> vertical
    pat = '0; pat[79] = 1'b1; pat[80] = 1'b1; pat[81] = 1'b1;
    load(pat);
    step(blen, wcnt, dcnt, dlast);
    chk("blinker_busy_len", blen, 601);
    chk("blinker_done_pulses", dcnt, 1);
    chk("blinker_done_last", dlast, 601);
    chk("blinker_writes", wcnt, 300);
    chk("blinker_pop", $countones(grid), 3);
    chk("blinker_c65", grid[65], 1);
    chk("blinker_c80", grid[80], 1);
    chk("blinker_c95", grid[95], 1);
    chk("blinker_alive", alive_count_o, 3);
    chk("blinker_gen1", gen_count_o, 1);
    step(blen, wcnt, dcnt, dlast);
    chk("blinker2_pop", $countones(grid), 3);
    chk("blinker2_c79", grid[79], 1);
    chk("blinker2_c80", grid[80], 1);
    chk("blinker2_c81", grid[81], 1);
    chk("blinker2_gen2", gen_count_o, 2);

    // Asynchronous reset between edges clears counters immediately
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_gen", gen_count_o, 0);
    chk("async_rst_alive", alive_count_o, 0);
    chk("async_rst_addr", Address_o, 37);
    chk("async_rst_busy", busy_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // start held high: back-to-back runs separated by one idle cycle
    start = 1'b1;
    tick();
    n = 0; g = 0;
    @(negedge clk);
    while (busy_o && g < 2000) begin n++; g++; @(negedge clk); end
    chk("held_run1_len", n, 601);
    n = 0; g = 0;
    while (!busy_o && g < 10) begin n++; g++; @(negedge clk); end
    chk("held_idle_gap", n, 1);
    start = 1'b0;
    n = 0; g = 0;
    while (busy_o && g < 2000) begin n++; g++; @(negedge clk); end
    chk("held_run2_len", n, 601);
    @(posedge clk); #1;
    chk("held_gen", gen_count_o, 2);

    // Extra start pulse at scan cycle 100 is ignored and not queued
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    @(negedge clk);
    while (busy_o && g < 2000) begin g++; @(negedge clk); end
    chk("extra_start_timeout", g >= 2000, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_queued_start", busy_o, 0);
    end
    @(posedge clk); #1;
    chk("extra_start_gen", gen_count_o, 3);

    // Reset in the middle of the commit pass
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    @(negedge clk);
    while (!(busy_o && w_e_o && Address_o == 9'd150) && g < 1000) begin g++; @(negedge clk); end
    chk("reach_commit_150", g < 1000, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_gen", gen_count_o, 0);
    chk("midrst_we", w_e_o, 0);
    wcnt = 0;
    repeat (5) begin @(negedge clk); if (w_e_o) wcnt++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (w_e_o) wcnt++; end
    chk("midrst_no_writes", wcnt, 0);
    @(posedge clk); #1;

    // Empty grid
    load('0);
    step(blen, wcnt, dcnt, dlast);
    chk("empty_alive", alive_count_o, 0);
    chk("empty_busy_len", blen, FRZ ? 301 : 601);
    chk("empty_writes", wcnt, FRZ ? 0 : 300);
    chk("empty_stable", stable_o, FRZ);
    chk("empty_gen", gen_count_o, 1);

    // Block still life
    pat = '0; pat[95] = 1'b1; pat[96] = 1'b1; pat[110] = 1'b1; pat[111] = 1'b1;
    load(pat);
    step(blen, wcnt, dcnt, dlast);
    chk("block_alive", alive_count_o, 4);
    chk("block_stable", stable_o, FRZ);
    chk("block_writes", wcnt, FRZ ? 0 : 300);
    chk("block_busy_len", blen, FRZ ? 301 : 601);
    chk("block_gen", gen_count_o, 2);

    // Pseudo-random soup, two generations, edges and corners included
    pat = '0;
    for (int a = 0; a < 300; a++) pat[a] = ($urandom_range(0, 2) == 0);
    pat[0] = 1'b1; pat[1] = 1'b1; pat[15] = 1'b1; pat[299] = 1'b1; pat[298] = 1'b1; pat[284] = 1'b1;
    load(pat);
    step(blen, wcnt, dcnt, dlast);
    chk("soup1_alive", alive_count_o, $countones(grid));
    chk("soup1_stable", stable_o, 0);
    step(blen, wcnt, dcnt, dlast);
    chk("soup2_alive", alive_count_o, $countones(grid));
    chk("soup2_gen", gen_count_o, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
